// File: rtl/tdm_demux_pkg.sv
// Shared TDM definitions: FSM states, slot-width helper and default frame geometry common with the TX-side mux.
package tdm_pkg;

  localparam int NCH_DEF = 4;
  localparam int DW_DEF  = 8;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  function automatic int slot_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Incoming TDM word stream: one word per valid beat, sof marks slot 0. No backpressure.
interface tdm_demux_if
  import tdm_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_sof;

  modport master (output in_valid, in_data, in_sof);
  modport slave  (input  in_valid, in_data, in_sof);

endinterface

// File: rtl/tdm_slot_ctr.sv
// Mod-NCH slot counter with clear and load-to-1; priority clr > load1 > inc.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter  int NCH = NCH_DEF,
  localparam int SW  = slot_w(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          load1,
  input  logic          clr,
  output logic [SW-1:0] slot,
  output logic          last
);

  logic [SW-1:0] r_slot;

  assign slot = r_slot;
  assign last = (r_slot == SW'(NCH - 1));

  // Explicit wrap at NCH-1 keeps the count legal for non-power-of-2 NCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else if (clr) begin
      r_slot <= '0;
    end else if (load1) begin
      r_slot <= SW'(1);
    end else if (inc) begin
      r_slot <= last ? '0 : r_slot + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer with hunt/lock frame alignment and sticky sync error; one clock latency, always accepts.
// TDM_DEMUX_FRAME_LATCH_EN: stage slots in a shadow bank and publish whole frames only.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter  int NCH = NCH_DEF,
  parameter  int DW  = DW_DEF,
  localparam int SW  = slot_w(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  tdm_demux_if.slave        rx,
  input  logic              err_clr,
  output logic [NCH*DW-1:0] out_data,
  output logic [NCH-1:0]    out_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked,
  output logic [SW-1:0]     slot
);

  state_t r_state;
  state_t w_state_nxt;

  logic [NCH*DW-1:0] r_out_data;
  logic [NCH-1:0]    r_out_valid;
  logic              r_frame_done;
  logic              r_sync_err;

  logic          w_wr;
  logic [SW-1:0] w_wr_idx;
  logic          w_inc;
  logic          w_load1;
  logic          w_clr;
  logic          w_err;
  logic          w_fd;
  logic [SW-1:0] w_slot;
  logic          w_last;

  tdm_slot_ctr #(.NCH(NCH)) u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc),
    .load1 (w_load1),
    .clr   (w_clr),
    .slot  (w_slot),
    .last  (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_wr_idx    = '0;
    w_inc       = 1'b0;
    w_load1     = 1'b0;
    w_clr       = 1'b0;
    w_err       = 1'b0;
    w_fd        = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (rx.in_valid && rx.in_sof) begin
          w_wr        = 1'b1;
          w_load1     = 1'b1;
          w_state_nxt = LOCK;
        end
      end
      LOCK: begin
        if (rx.in_valid) begin
          if (rx.in_sof) begin
            // An early SOF restarts the frame in place; the partial one is abandoned.
            w_wr    = 1'b1;
            w_load1 = 1'b1;
            w_err   = (w_slot != '0);
          end else if (w_slot != '0) begin
            w_wr     = 1'b1;
            w_wr_idx = w_slot;
            w_inc    = 1'b1;
            w_fd     = w_last;
          end else begin
            w_err       = 1'b1;
            w_clr       = 1'b1;
            w_state_nxt = HUNT;
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_err <= 1'b0;
    end else if (w_err) begin
      r_sync_err <= 1'b1;
    end else if (err_clr) begin
      r_sync_err <= 1'b0;
    end
  end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
  logic [(NCH-1)*DW-1:0] r_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow     <= '0;
      r_out_data   <= '0;
      r_out_valid  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      for (int k = 0; k < NCH - 1; k++) begin
        if (w_wr && (w_wr_idx == SW'(k))) begin
          r_shadow[k*DW +: DW] <= rx.in_data;
        end
      end
      // The last slot bypasses the shadow bank so the frame publishes on its own beat.
      if (w_fd) begin
        r_out_data <= {rx.in_data, r_shadow};
      end
      r_out_valid  <= w_fd ? '1 : '0;
      r_frame_done <= w_fd;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data   <= '0;
      r_out_valid  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_wr && (w_wr_idx == SW'(k))) begin
          r_out_data[k*DW +: DW] <= rx.in_data;
        end
      end
      r_out_valid  <= w_wr ? (NCH'(1) << w_wr_idx) : '0;
      r_frame_done <= w_fd;
    end
  end
`endif

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign locked     = (r_state == LOCK);
  assign slot       = w_slot;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (NCH=4, DW=8); expectations follow TDM_DEMUX_FRAME_LATCH_EN when defined.
module tb_tdm_demux;
  import tdm_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 8;
`ifdef TDM_DEMUX_FRAME_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              err_clr = 1'b0;
  logic [NCH*DW-1:0] out_data;
  logic [NCH-1:0]    out_valid;
  logic              frame_done;
  logic              sync_err;
  logic              locked;
  logic [1:0]        slot;

  int n_tests = 0;
  int n_fail  = 0;

  tdm_demux_if #(.DW(DW)) bus ();

  tdm_demux #(.NCH(NCH), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (bus),
    .err_clr    (err_clr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked),
    .slot       (slot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the beat's result visible.
  task automatic send(input logic [7:0] d, input logic s);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sof   = s;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] clean [4];
    int         gaps  [3];
    clean = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    gaps  = '{2, 0, 3};
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sof   = 1'b0;

    #12;
    chk("rst_data",   out_data,   32'h0);
    chk("rst_valid",  out_valid,  32'h0);
    chk("rst_fd",     frame_done, 32'h0);
    chk("rst_err",    sync_err,   32'h0);
    chk("rst_locked", locked,     32'h0);
    chk("rst_slot",   slot,       32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Words without SOF while hunting are dropped.
    send(8'h11, 1'b0);
    chk("hunt_valid", out_valid, 32'h0);
    chk("hunt_locked", locked, 32'h0);
    send(8'h22, 1'b0);
    chk("hunt_data", out_data, 32'h0);
    chk("hunt_slot", slot, 32'h0);

    for (int i = 0; i < 4; i++) begin
      send(clean[i], i == 0);
      chk($sformatf("clean_valid%0d", i), out_valid,
          LATCH ? ((i == 3) ? 32'hF : 32'h0) : (32'h1 << i));
      chk($sformatf("clean_fd%0d", i), frame_done, (i == 3) ? 32'h1 : 32'h0);
      chk($sformatf("clean_slot%0d", i), slot, (i + 1) % 4);
    end
    chk("clean_data", out_data, 32'hA3A2A1A0);
    chk("clean_locked", locked, 32'h1);
    @(negedge clk);
    chk("idle_valid", out_valid, 32'h0);
    chk("idle_fd", frame_done, 32'h0);

    // Early SOF.
    send(8'hB0, 1'b1);
    send(8'hB1, 1'b0);
    send(8'hC0, 1'b1);
    chk("early_err",    sync_err,   32'h1);
    chk("early_slot",   slot,       32'h1);
    chk("early_fd",     frame_done, 32'h0);
    chk("early_locked", locked,     32'h1);
    chk("early_data",   out_data,   LATCH ? 32'hA3A2A1A0 : 32'hA3A2B1C0);
    pulse_clr();
    chk("early_clr", sync_err, 32'h0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    chk("c_fd",   frame_done, 32'h1);
    chk("c_data", out_data,   32'hC3C2C1C0);

    // Missing SOF at slot 0.
    send(8'hD0, 1'b0);
    chk("miss_err",    sync_err,  32'h1);
    chk("miss_locked", locked,    32'h0);
    chk("miss_valid",  out_valid, 32'h0);
    chk("miss_data",   out_data,  32'hC3C2C1C0);
    chk("miss_slot",   slot,      32'h0);
    pulse_clr();
    chk("miss_clr", sync_err, 32'h0);
    send(8'hE0, 1'b1);
    chk("relock_locked", locked,   32'h1);
    chk("relock_data",   out_data, LATCH ? 32'hC3C2C1C0 : 32'hC3C2C1E0);
    chk("relock_slot",   slot,     32'h1);

    // New error and err_clr in the same cycle: error wins.
    err_clr = 1'b1;
    send(8'hE8, 1'b1);
    err_clr = 1'b0;
    chk("errwin_err",  sync_err, 32'h1);
    chk("errwin_slot", slot,     32'h1);
    send(8'hE9, 1'b0);
    send(8'hEA, 1'b0);
    send(8'hEB, 1'b0);
    chk("e_fd",   frame_done, 32'h1);
    chk("e_data", out_data,   32'hEBEAE9E8);
    pulse_clr();
    chk("e_clr", sync_err, 32'h0);

    // Gapped frame.
    for (int i = 0; i < 4; i++) begin
      send(8'(i + 1), i == 0);
      if (i < 3) begin
        repeat (gaps[i]) @(negedge clk);
        chk($sformatf("gap_slot%0d", i), slot, i + 1);
        if (gaps[i] > 0) chk($sformatf("gap_valid%0d", i), out_valid, 32'h0);
      end
    end
    chk("gap_fd",    frame_done, 32'h1);
    chk("gap_valid", out_valid,  LATCH ? 32'hF : 32'h8);
    chk("gap_data",  out_data,   32'h04030201);
    chk("gap_err",   sync_err,   32'h0);

    // Asynchronous reset mid-frame.
    send(8'h10, 1'b1);
    send(8'h20, 1'b0);
    chk("pre_rst_data", out_data, LATCH ? 32'h04030201 : 32'h04032010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data",   out_data,  32'h0);
    chk("arst_locked", locked,    32'h0);
    chk("arst_slot",   slot,      32'h0);
    chk("arst_valid",  out_valid, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h31, 1'b1);
    send(8'h32, 1'b0);
    chk("post_part_data", out_data, LATCH ? 32'h0 : 32'h00003231);
    send(8'h33, 1'b0);
    send(8'h34, 1'b0);
    chk("post_data",  out_data,   32'h34333231);
    chk("post_valid", out_valid,  LATCH ? 32'hF : 32'h8);
    chk("post_fd",    frame_done, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
